// File: rtl/deser_arb_ctrl.sv
// Two-requester round-robin front end for a byte-serial deserializer.
// Each granted word is fed MSB first, then the echoed word is checked and returned.
module deser_arb_ctrl #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  req,
    input  logic [31:0] req_word0,
    input  logic [31:0] req_word1,
    output logic [1:0]  req_ack,
    output logic        des_cin,
    output logic [7:0]  des_din,
    input  logic        des_done,
    input  logic [31:0] des_dout,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_src,
    output logic        err_timeout,
    output logic        err_mismatch,
    output logic        busy
);

    localparam logic [3:0] WAIT_LIMIT = 4'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FEED,
        S_WAIT,
        S_OUT
    } state_e;

    state_e      state_q, state_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [3:0]  wait_cnt_q, wait_cnt_d;
    logic [31:0] word_q, word_d;
    logic        src_q, src_d;
    logic        last_q, last_d;
    logic [31:0] data_q, data_d;
    logic        mismatch_q, mismatch_d;

    logic        grant_valid;
    logic        grant_idx;

    // last_q holds the previous winner; on contention the other one wins
    always_comb begin
        grant_valid = |req;
        unique case (req)
            2'b01:   grant_idx = 1'b0;
            2'b10:   grant_idx = 1'b1;
            2'b11:   grant_idx = ~last_q;
            default: grant_idx = 1'b0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        word_d      = word_q;
        src_d       = src_q;
        last_d      = last_q;
        data_d      = data_q;
        mismatch_d  = mismatch_q;
        req_ack     = '0;
        des_cin     = 1'b0;
        des_din     = '0;
        out_valid   = 1'b0;
        err_timeout = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (grant_valid) begin
                    req_ack    = grant_idx ? 2'b10 : 2'b01;
                    word_d     = grant_idx ? req_word1 : req_word0;
                    src_d      = grant_idx;
                    last_d     = grant_idx;
                    byte_cnt_d = '0;
                    state_d    = S_FEED;
                end
            end
            S_FEED: begin
                des_cin = (byte_cnt_q == 2'd0);
                unique case (byte_cnt_q)
                    2'd0: des_din = word_q[31:24];
                    2'd1: des_din = word_q[23:16];
                    2'd2: des_din = word_q[15:8];
                    2'd3: des_din = word_q[7:0];
                endcase
                byte_cnt_d = byte_cnt_q + 2'd1;
                if (byte_cnt_q == 2'd3) begin
                    wait_cnt_d = '0;
                    state_d    = S_WAIT;
                end
            end
            S_WAIT: begin
                // the limit cycle itself no longer accepts des_done
                if (wait_cnt_q >= WAIT_LIMIT) begin
                    err_timeout = 1'b1;
                    state_d     = S_IDLE;
                end else if (des_done) begin
                    data_d  = des_dout;
                    state_d = S_OUT;
                    if (des_dout != word_q) begin
                        mismatch_d = 1'b1;
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q + 4'd1;
                end
            end
            S_OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
        endcase

        // pulses must not escape while reset is being applied
        if (!rst_n) begin
            req_ack     = '0;
            err_timeout = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            byte_cnt_q <= '0;
            wait_cnt_q <= '0;
            word_q     <= '0;
            src_q      <= 1'b0;
            last_q     <= 1'b1;
            data_q     <= '0;
            mismatch_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            word_q     <= word_d;
            src_q      <= src_d;
            last_q     <= last_d;
            data_q     <= data_d;
            mismatch_q <= mismatch_d;
        end
    end

    assign busy         = (state_q != S_IDLE);
    assign out_data     = data_q;
    assign out_src      = src_q;
    assign err_mismatch = mismatch_q;

endmodule

// File: tb/tb_deser_arb_ctrl.sv
// Bench for deser_arb_ctrl: directed scenarios with literal expectations, then
// randomized traffic, all cross-checked every cycle by a transfer-timeline model.
module tb_deser_arb_ctrl;

    localparam int TO = 15;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req = '0;
    logic [31:0] req_word0 = '0;
    logic [31:0] req_word1 = '0;
    logic [1:0]  req_ack;
    logic        des_cin;
    logic [7:0]  des_din;
    logic        des_done = 1'b0;
    logic [31:0] des_dout = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic        out_src;
    logic        err_timeout;
    logic        err_mismatch;
    logic        busy;

    int checks = 0;
    int failures = 0;

    deser_arb_ctrl #(.TIMEOUT(TO)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req),
        .req_word0    (req_word0),
        .req_word1    (req_word1),
        .req_ack      (req_ack),
        .des_cin      (des_cin),
        .des_din      (des_din),
        .des_done     (des_done),
        .des_dout     (des_dout),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_src      (out_src),
        .err_timeout  (err_timeout),
        .err_mismatch (err_mismatch),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- deserializer responder and random requesters ----------------
    int          d_n = 0;
    int          d_dly = 0;
    int          d_cfg_delay = 2;
    logic [31:0] d_sh = '0;
    bit          d_force_en = 1'b0;
    logic [31:0] d_force = '0;
    bit          rnd_mode = 1'b0;
    bit          spur_en = 1'b0;
    logic [1:0]  ack_seen = '0;

    initial forever begin
        @(negedge clk);
        ack_seen = req_ack;
    end

    task automatic pick_deser();
        int r;
        r = $urandom_range(0, 99);
        if (r < 60)      d_cfg_delay = $urandom_range(1, 4);
        else if (r < 70) d_cfg_delay = TO;
        else if (r < 78) d_cfg_delay = TO + 1;
        else if (r < 85) d_cfg_delay = 0;
        else             d_cfg_delay = $urandom_range(5, 12);
        d_force_en = ($urandom_range(0, 9) == 0);
        d_force    = $urandom();
    endtask

    task automatic rand_drive();
        for (int i = 0; i < 2; i++) begin
            if (req[i] && ack_seen[i]) begin
                if ($urandom_range(0, 1) == 0) req[i] = 1'b0;
                if (i == 0) req_word0 = $urandom(); else req_word1 = $urandom();
            end else if (!req[i] && $urandom_range(0, 3) == 0) begin
                req[i] = 1'b1;
                if (i == 0) req_word0 = $urandom(); else req_word1 = $urandom();
            end
        end
        out_ready = ($urandom_range(0, 9) < 6);
        rst_n     = ($urandom_range(0, 399) != 0);
    endtask

    // advance to just after the next rising edge and drive this cycle's inputs
    task automatic cycle();
        bit feeding;
        @(posedge clk);
        #1;
        des_done = 1'b0;
        des_dout = $urandom();
        feeding  = 1'b0;
        if (!rst_n) begin
            d_n   = 0;
            d_dly = 0;
        end
        if (busy && des_cin) begin
            d_sh    = {24'b0, des_din};
            d_n     = 1;
            feeding = 1'b1;
            if (rnd_mode) pick_deser();
        end else if (busy && d_n > 0 && d_n < 4) begin
            d_sh    = {d_sh[23:0], des_din};
            d_n++;
            feeding = 1'b1;
            if (d_n == 4) d_dly = d_cfg_delay;
        end else if (d_dly > 0) begin
            d_dly--;
            if (d_dly == 0) begin
                des_done = 1'b1;
                des_dout = d_force_en ? d_force : d_sh;
            end
        end
        if (spur_en && !des_done && d_dly == 0 && (feeding || !busy || out_valid) &&
            $urandom_range(0, 7) == 0) begin
            des_done = 1'b1;
        end
        if (rnd_mode) rand_drive();
    endtask

    // ---------------- timeline reference model ----------------
    // m_age counts cycles since the ack cycle: 1..4 feed bytes, 5.. waiting.
    bit          m_busy = 1'b0;
    bit          m_res_v = 1'b0;
    bit          m_last = 1'b1;
    bit          m_mis = 1'b0;
    bit          m_src = 1'b0;
    int          m_age = 0;
    logic [31:0] m_word = '0;
    logic [31:0] m_res = '0;

    initial begin : model
        logic [1:0] e_ack;
        logic [7:0] e_din;
        bit         e_cin, e_valid, e_to, g;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_busy  = 1'b0;
                m_res_v = 1'b0;
                m_last  = 1'b1;
                m_mis   = 1'b0;
                m_res   = '0;
                continue;
            end
            e_ack = '0; e_din = '0; e_cin = 1'b0; e_valid = 1'b0; e_to = 1'b0; g = 1'b0;
            if (!m_busy) begin
                if (req != 2'b00) begin
                    g     = (req == 2'b11) ? !m_last : req[1];
                    e_ack = g ? 2'b10 : 2'b01;
                end
            end else if (m_res_v) begin
                e_valid = 1'b1;
            end else if (m_age >= 1 && m_age <= 4) begin
                e_din = 8'(m_word >> (8 * (4 - m_age)));
                e_cin = (m_age == 1);
            end else if (m_age - 5 == TO) begin
                e_to = 1'b1;
            end

            chk("m_req_ack", 32'(req_ack), 32'(e_ack));
            chk("m_des_cin", 32'(des_cin), 32'(e_cin));
            chk("m_des_din", 32'(des_din), 32'(e_din));
            chk("m_busy", 32'(busy), 32'(m_busy));
            chk("m_out_valid", 32'(out_valid), 32'(e_valid));
            chk("m_err_timeout", 32'(err_timeout), 32'(e_to));
            chk("m_err_mismatch", 32'(err_mismatch), 32'(m_mis));
            if (e_valid) begin
                chk("m_out_data", out_data, m_res);
                chk("m_out_src", 32'(out_src), 32'(m_src));
            end

            if (!m_busy) begin
                if (req != 2'b00) begin
                    m_last  = g;
                    m_src   = g;
                    m_word  = g ? req_word1 : req_word0;
                    m_busy  = 1'b1;
                    m_res_v = 1'b0;
                    m_age   = 1;
                end
            end else if (m_res_v) begin
                if (out_ready) m_busy = 1'b0;
            end else begin
                if (m_age >= 5) begin
                    if (m_age - 5 == TO) begin
                        m_busy = 1'b0;
                    end else if (des_done) begin
                        m_res_v = 1'b1;
                        m_res   = des_dout;
                        if (des_dout != m_word) m_mis = 1'b1;
                    end
                end
                m_age++;
            end
        end
    end

    // ---------------- directed scenarios, then random traffic ----------------
    logic [7:0] a_bytes [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    int gs [4];
    int ss [4];

    task automatic wait_valid(input string name, input int budget, output int n);
        n = 0;
        while (n < budget) begin
            cycle();
            @(negedge clk);
            n++;
            if (out_valid) break;
        end
        chk({name, "_valid_reached"}, 32'(out_valid), 1);
    endtask

    task automatic check_all_zero(input string name);
        chk({name, "_req_ack"}, 32'(req_ack), 0);
        chk({name, "_des_cin"}, 32'(des_cin), 0);
        chk({name, "_des_din"}, 32'(des_din), 0);
        chk({name, "_out_valid"}, 32'(out_valid), 0);
        chk({name, "_out_data"}, out_data, 0);
        chk({name, "_out_src"}, 32'(out_src), 0);
        chk({name, "_err_timeout"}, 32'(err_timeout), 0);
        chk({name, "_err_mismatch"}, 32'(err_mismatch), 0);
        chk({name, "_busy"}, 32'(busy), 0);
    endtask

    initial begin : stim
        int n, k, ng, ns;
        bit saw_v;

        rst_n = 1'b0;
        cycle();
        cycle();
        rst_n = 1'b1;
        @(negedge clk);
        check_all_zero("rst");

        // single transfer, echo two cycles after the last byte
        cycle();
        d_cfg_delay = 2;
        req = 2'b01;
        req_word0 = 32'hA1B2C3D4;
        @(negedge clk);
        chk("A_ack", 32'(req_ack), 1);
        cycle();
        req = 2'b00;
        for (int i = 0; i < 4; i++) begin
            if (i != 0) cycle();
            @(negedge clk);
            chk("A_din", 32'(des_din), 32'(a_bytes[i]));
            chk("A_cin", 32'(des_cin), 32'(i == 0));
            chk("A_ack_once", 32'(req_ack), 0);
        end
        wait_valid("A", 10, n);
        chk("A_latency", n, 3);
        chk("A_data", out_data, 32'hA1B2C3D4);
        chk("A_src", 32'(out_src), 0);
        chk("A_mis", 32'(err_mismatch), 0);

        // contention from a fresh reset: grants alternate starting with 0
        cycle();
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        d_cfg_delay = 1;
        req = 2'b11;
        req_word0 = $urandom();
        req_word1 = $urandom();
        ng = 0;
        ns = 0;
        for (int c = 0; c < 200 && (ng < 4 || ns < 4); c++) begin
            @(negedge clk);
            if (req_ack != 2'b00 && ng < 4) begin gs[ng] = int'(req_ack); ng++; end
            if (out_valid && out_ready && ns < 4) begin ss[ns] = int'(out_src); ns++; end
            cycle();
            if (ack_seen[0]) req_word0 = $urandom();
            if (ack_seen[1]) req_word1 = $urandom();
        end
        req = 2'b00;
        chk("B_grants_seen", ng, 4);
        chk("B_results_seen", ns, 4);
        for (int i = 0; i < 4; i++) begin
            chk("B_grant_order", gs[i], (i % 2 == 0) ? 1 : 2);
            chk("B_src_order", ss[i], i % 2);
        end

        // timeout: no des_done at all
        d_cfg_delay = 0;
        req = 2'b01;
        req_word0 = $urandom();
        @(negedge clk);
        chk("C_ack", 32'(req_ack), 1);
        cycle();
        req = 2'b00;
        @(negedge clk);
        chk("C_cin", 32'(des_cin), 1);
        k = 0;
        saw_v = 1'b0;
        while (k < 40) begin
            cycle();
            @(negedge clk);
            k++;
            if (out_valid) saw_v = 1'b1;
            if (err_timeout) break;
        end
        chk("C_timeout_after_wait_entry", k - 4, TO);
        chk("C_no_valid", 32'(saw_v), 0);
        cycle();
        @(negedge clk);
        chk("C_busy_fall", 32'(busy), 0);
        chk("C_timeout_one_cycle", 32'(err_timeout), 0);

        // mismatch, then a clean transfer keeps the sticky flag
        cycle();
        d_cfg_delay = 2;
        d_force_en = 1'b1;
        d_force = 32'hDEADBEEF;
        req = 2'b01;
        req_word0 = 32'h01020304;
        @(negedge clk);
        chk("D_ack", 32'(req_ack), 1);
        cycle();
        req = 2'b00;
        wait_valid("D", 20, n);
        chk("D_data", out_data, 32'hDEADBEEF);
        chk("D_mis", 32'(err_mismatch), 1);
        cycle();
        d_force_en = 1'b0;
        req = 2'b01;
        req_word0 = 32'h11223344;
        @(negedge clk);
        chk("D2_ack", 32'(req_ack), 1);
        cycle();
        req = 2'b00;
        wait_valid("D2", 20, n);
        chk("D2_data", out_data, 32'h11223344);
        chk("D2_mis_sticky", 32'(err_mismatch), 1);

        // backpressure with requester 1 pending
        cycle();
        out_ready = 1'b0;
        req = 2'b01;
        req_word0 = 32'h55AA7788;
        @(negedge clk);
        chk("E_ack", 32'(req_ack), 1);
        cycle();
        req = 2'b00;
        wait_valid("E", 20, n);
        chk("E_data", out_data, 32'h55AA7788);
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (i == 0) begin
                req = 2'b10;
                req_word1 = 32'h0BADF00D;
            end
            @(negedge clk);
            chk("E_hold_valid", 32'(out_valid), 1);
            chk("E_hold_data", out_data, 32'h55AA7788);
            chk("E_hold_no_ack", 32'(req_ack), 0);
        end
        cycle();
        out_ready = 1'b1;
        @(negedge clk);
        chk("E_hs_no_ack", 32'(req_ack), 0);
        chk("E_hs_valid", 32'(out_valid), 1);
        cycle();
        @(negedge clk);
        chk("E_ack_after_hs", 32'(req_ack), 2);
        cycle();
        req = 2'b00;
        wait_valid("E2", 20, n);
        chk("E2_data", out_data, 32'h0BADF00D);
        chk("E2_src", 32'(out_src), 1);

        // reset after two fed bytes; priority returns to requester 0
        cycle();
        req = 2'b01;
        req_word0 = 32'hCAFE0102;
        @(negedge clk);
        chk("F_ack", 32'(req_ack), 1);
        cycle();
        req = 2'b00;
        @(negedge clk);
        chk("F_b0", 32'(des_din), 32'hCA);
        cycle();
        @(negedge clk);
        chk("F_b1", 32'(des_din), 32'hFE);
        cycle();
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        @(negedge clk);
        check_all_zero("F_rst");
        cycle();
        req = 2'b11;
        req_word0 = $urandom();
        req_word1 = $urandom();
        @(negedge clk);
        chk("F_rr_after_reset", 32'(req_ack), 1);

        // randomized traffic
        rnd_mode = 1'b1;
        spur_en = 1'b1;
        repeat (4000) cycle();
        rnd_mode = 1'b0;
        spur_en = 1'b0;
        d_force_en = 1'b0;
        rst_n = 1'b1;
        req = 2'b00;
        out_ready = 1'b1;
        repeat (30) cycle();
        @(negedge clk);
        chk("end_idle", 32'(busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
